// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter: single-outstanding arbiter for fetch/data memory ports
// Revision: 1.0
// ============================================================================
module unified_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic [DW-1:0] IRdata,
    output logic          IReady,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWdata,
    output logic [DW-1:0] DRdata,
    output logic          DReady,
    output logic          StallF,
    output logic          StallM,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    input  logic [DW-1:0] MemRdata,
    input  logic          MemAck,
    output logic          BusErr
);

    localparam int            CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);
    localparam logic [AW-1:0] WORD_MSK = ~AW'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]    irdata_q, irdata_d;
    logic [DW-1:0]    drdata_q, drdata_d;
    logic             iready_q, iready_d;
    logic             dready_q, dready_d;
    logic             buserr_q, buserr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [DW-1:0]    w_rdata;
    logic             w_done;

    assign w_cnt_nxt = cnt_q + CNT_W'(1);
    // A timeout completes like an ack carrying zero data; a real ack wins.
    assign w_done    = MemAck || (w_cnt_nxt == TMO_VAL);
    assign w_rdata   = MemAck ? MemRdata : '0;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            iready_q    <= 1'b0;
            dready_q    <= 1'b0;
            buserr_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
            iready_q    <= iready_d;
            dready_q    <= dready_d;
            buserr_q    <= buserr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        iready_d    = 1'b0;
        dready_d    = 1'b0;
        buserr_d    = buserr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                // A port whose Ready is high this cycle is not eligible.
                if (DReq && !dready_q) begin
                    state_d     = DBUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = DWe;
                    mem_addr_d  = DAddr & WORD_MSK;
                    mem_wdata_d = DWdata;
                    cnt_d       = '0;
                end else if (IReq && !iready_q) begin
                    state_d    = IBUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = IAddr & WORD_MSK;
                    cnt_d      = '0;
                end
            end
            IBUSY, DBUSY: begin
                if (w_done) begin
                    if (!MemAck) begin
                        buserr_d = 1'b1;
                    end
                    if (state_q == IBUSY) begin
                        irdata_d = w_rdata;
                        iready_d = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            drdata_d = w_rdata;
                        end
                        dready_d = 1'b1;
                    end
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = w_cnt_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign IRdata   = irdata_q;
    assign IReady   = iready_q;
    assign DRdata   = drdata_q;
    assign DReady   = dready_q;
    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWdata = mem_wdata_q;
    assign BusErr   = buserr_q;
    assign StallF   = IReq & ~iready_q;
    assign StallM   = DReq & ~dready_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_unified_mem_arbiter: directed + randomized bench against a transaction model
// Revision: 1.0
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        IReq, DReq, DWe, MemAck;
    logic [31:0] IAddr, DAddr, DWdata, MemRdata;
    logic [31:0] IRdata, DRdata, MemAddr, MemWdata;
    logic        IReady, DReady, StallF, StallM, MemReq, MemWe, BusErr;

    unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .Reset(Reset),
        .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IReady(IReady),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
        .DRdata(DRdata), .DReady(DReady),
        .StallF(StallF), .StallM(StallM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemRdata(MemRdata), .MemAck(MemAck), .BusErr(BusErr)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Transaction-level model: who owns the memory, when it was granted,
    // and what the registered outputs must currently show.
    int          owner;      // 0 none, 1 fetch, 2 data
    int          grant_cyc;
    int          cyc;
    logic        e_memreq, e_memwe, e_iready, e_dready, e_buserr;
    logic [31:0] e_memaddr, e_memwdata, e_irdata, e_drdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0; grant_cyc = 0;
        e_memreq = 0; e_memwe = 0; e_iready = 0; e_dready = 0; e_buserr = 0;
        e_memaddr = 0; e_memwdata = 0; e_irdata = 0; e_drdata = 0;
    endtask

    task automatic model_step();
        logic        nir, ndr;
        logic [31:0] data;
        nir = 0; ndr = 0;
        if (owner == 0) begin
            if (DReq && !e_dready) begin
                owner = 2; grant_cyc = cyc;
                e_memreq = 1; e_memwe = DWe;
                e_memaddr = DAddr & 32'hFFFF_FFFC; e_memwdata = DWdata;
            end else if (IReq && !e_iready) begin
                owner = 1; grant_cyc = cyc;
                e_memreq = 1; e_memwe = 0;
                e_memaddr = IAddr & 32'hFFFF_FFFC;
            end
        end else if (MemAck || (cyc - grant_cyc) == TMO) begin
            data = MemAck ? MemRdata : 32'h0;
            if (!MemAck) e_buserr = 1;
            if (owner == 1) begin
                e_irdata = data; nir = 1;
            end else begin
                if (!e_memwe) e_drdata = data;
                ndr = 1;
            end
            owner = 0; e_memreq = 0;
        end
        e_iready = nir; e_dready = ndr;
        cyc++;
    endtask

    task automatic compare_all();
        check("StallF", StallF, IReq & ~e_iready);
        check("StallM", StallM, DReq & ~e_dready);
        check("MemReq", MemReq, e_memreq);
        check("IReady", IReady, e_iready);
        check("DReady", DReady, e_dready);
        check("BusErr", BusErr, e_buserr);
        check("IRdata", IRdata, e_irdata);
        check("DRdata", DRdata, e_drdata);
        if (e_memreq) begin
            check("MemWe", MemWe, e_memwe);
            check("MemAddr", MemAddr, e_memaddr);
            check("MemWdata", MemWdata, e_memwdata);
        end
    endtask

    // Called at a falling edge with inputs already set for this cycle.
    task automatic tick();
        #1;
        compare_all();
        if (Reset) model_step();
        else       model_reset();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    bit i_act, d_act;
    int ack_pct;

    initial begin
        cyc = 0;
        Reset = 0; IReq = 1; IAddr = 32'h0000_0047;
        DReq = 0; DWe = 0; DAddr = 0; DWdata = 0; MemAck = 0; MemRdata = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        check("rst_MemReq", MemReq, 0);
        check("rst_MemAddr", MemAddr, 0);
        check("rst_IReady", IReady, 0);
        check("rst_BusErr", BusErr, 0);
        check("rst_StallF", StallF, 1);
        tick();

        // Release reset: first grant on the next rising edge
        Reset = 1;
        tick();
        check("rel_MemReq", MemReq, 1);
        check("rel_MemAddr", MemAddr, 32'h0000_0044);
        MemAck = 1; MemRdata = 32'h0BAD_0001;
        tick();
        IReq = 0; MemAck = 0;
        tick();

        // Single fetch with immediate ack
        IReq = 1; IAddr = 32'h0000_0044; MemAck = 1; MemRdata = 32'h2009_0005;
        #1 check("fetch_stall0", StallF, 1);
        tick();
        check("fetch_stall1", StallF, 1);
        check("fetch_MemAddr", MemAddr, 32'h0000_0044);
        tick();
        check("fetch_IReady", IReady, 1);
        check("fetch_IRdata", IRdata, 32'h2009_0005);
        check("fetch_stall2", StallF, 0);
        IReq = 0; MemAck = 0;
        tick();
        check("fetch_pulse_end", IReady, 0);

        // Contention: data first, fetch granted at the DReady edge
        IReq = 1; IAddr = 32'h0000_0200;
        DReq = 1; DWe = 0; DAddr = 32'h0000_0100;
        MemAck = 1; MemRdata = 32'hCAFE_F00D;
        tick();
        check("cont_MemAddr0", MemAddr, 32'h0000_0100);
        tick();
        check("cont_DReady", DReady, 1);
        check("cont_DRdata", DRdata, 32'hCAFE_F00D);
        check("cont_IReady_early", IReady, 0);
        DReq = 0;
        tick();
        check("cont_MemAddr1", MemAddr, 32'h0000_0200);
        MemRdata = 32'h1111_2222;
        tick();
        check("cont_IReady", IReady, 1);
        check("cont_IRdata", IRdata, 32'h1111_2222);
        IReq = 0; MemAck = 0;
        tick();

        // Store, ack on the 4th busy cycle (same edge the counter would expire)
        DReq = 1; DWe = 1; DAddr = 32'h0000_0020; DWdata = 32'h1234_5678;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("st_MemWe", MemWe, 1);
            check("st_MemWdata", MemWdata, 32'h1234_5678);
            if (k == 3) MemAck = 1;
            tick();
        end
        check("st_DReady", DReady, 1);
        check("st_DRdata", DRdata, 32'hCAFE_F00D);
        check("st_BusErr", BusErr, 0);
        DReq = 0; MemAck = 0;
        tick();
        check("st_pulse_end", DReady, 0);

        // Timeout: no ack at all
        IReq = 1; IAddr = 32'h0000_0080;
        tick();
        repeat (TMO) begin
            check("to_MemReq", MemReq, 1);
            tick();
        end
        check("to_IReady", IReady, 1);
        check("to_IRdata", IRdata, 32'h0);
        check("to_BusErr", BusErr, 1);
        IReq = 0; MemAck = 1;
        tick();
        check("to_late_ack_MemReq", MemReq, 0);
        check("to_late_ack_IReady", IReady, 0);
        check("to_sticky", BusErr, 1);
        MemAck = 0;
        tick();

        // Reset during a data transaction
        DReq = 1; DWe = 0; DAddr = 32'h0000_0300;
        tick();
        check("mr_busy", MemReq, 1);
        Reset = 0;
        model_reset();
        #1;
        check("mr_async_MemReq", MemReq, 0);
        check("mr_BusErr", BusErr, 0);
        tick();
        Reset = 1; DReq = 0;
        tick();
        check("mr_no_DReady", DReady, 0);
        check("mr_idle", MemReq, 0);

        // Randomized traffic
        i_act = 0; d_act = 0; ack_pct = 80;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ack_pct = 80;
                    1:       ack_pct = 30;
                    default: ack_pct = 0;
                endcase
            end
            if (i_act && e_iready) begin i_act = 0; IReq = 0; end
            if (d_act && e_dready) begin d_act = 0; DReq = 0; end
            if (!i_act && $urandom_range(0, 3) == 0) begin
                i_act = 1; IReq = 1; IAddr = $urandom;
            end
            if (!d_act && $urandom_range(0, 4) == 0) begin
                d_act = 1; DReq = 1; DWe = $urandom_range(0, 1) == 1;
                DAddr = $urandom; DWdata = $urandom;
            end
            MemAck   = ($urandom_range(0, 99) < ack_pct);
            MemRdata = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
